// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between the F-stage and the
// combinational instruction memory.
//   im_addr   byte address of the word being fetched (driven by F-stage)
//   im_instr  instruction word at im_addr, valid in the same cycle
// Modports:
//   master  F-stage side (drives im_addr, receives im_instr)
//   slave   memory side (receives im_addr, drives im_instr)
interface fetch_stage_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;

  modport master (output im_addr, input  im_instr);
  modport slave  (input  im_addr, output im_instr);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: F-stage of the 5-stage MIPS pipeline.
// Owns the PC, fetches from a combinational instruction memory, registers
// the word into IF/ID and resolves next-PC from D-stage branch/jump
// controls. Hazard stall holds PC and IF/ID; delay slot is architectural
// (the instruction behind a taken branch/jump is never squashed).
//
// Optional feature macro: PC_CHECK_EN
//   defined   - F_exc flags misaligned or out-of-window fetch addresses and
//               a nop is captured into IF/ID instead of the fetched word
//   undefined - F_exc is constant 0, the fetched word passes unchecked
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   stall     hazard-unit stall (holds PC and IF/ID)
//   npc_sel   next-PC select: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr
//   br_cond   D-stage branch comparison result (npc_sel=1 only)
//   D_imm     D-stage instr[25:0] (branch offset / jump index)
//   D_rs_val  forwarded rs value, jr target
//   im        instruction-memory bus (master)
//   F_pc      current PC
//   D_instr   IF/ID instruction
//   D_pc      IF/ID PC
//   D_pc8     D_pc + 8, link value
//   D_valid   IF/ID holds a real fetched instruction
//   F_exc     fetch-address fault
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_7000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [1:0]          npc_sel,
  input  logic                br_cond,
  input  logic [25:0]         D_imm,
  input  logic [31:0]         D_rs_val,
  fetch_stage_if.master       im,
  output logic [31:0]         F_pc,
  output logic [31:0]         D_instr,
  output logic [31:0]         D_pc,
  output logic [31:0]         D_pc8,
  output logic                D_valid,
  output logic                F_exc
);

  logic [31:0] pc_q;
  logic [31:0] d_instr_q;
  logic [31:0] d_pc_q;
  logic        d_valid_q;
  logic [31:0] npc;
  logic [31:0] fetch_word;
  logic [1:0]  sel_eff;
  logic [31:0] seq_pc;
  logic [31:0] br_target;

  assign im.im_addr = pc_q;
  assign F_pc       = pc_q;
  assign D_instr    = d_instr_q;
  assign D_pc       = d_pc_q;
  assign D_pc8      = d_pc_q + 32'd8;
  assign D_valid    = d_valid_q;

`ifdef PC_CHECK_EN
  logic fault;
  assign fault      = (pc_q[1:0] != 2'b00) || (pc_q > PC_LIMIT) || (pc_q < PC_RESET);
  assign F_exc      = fault;
  assign fetch_word = fault ? '0 : im.im_instr;
`else
  assign F_exc      = 1'b0;
  assign fetch_word = im.im_instr;
`endif

  // An empty IF/ID slot carries no real control, so it cannot redirect.
  assign sel_eff   = d_valid_q ? npc_sel : 2'd0;
  assign seq_pc    = pc_q + 32'd4;
  // Branch targets are relative to the delay slot (D_pc+4), not F_pc.
  assign br_target = d_pc_q + 32'd4 + {{14{D_imm[15]}}, D_imm[15:0], 2'b00};

  always_comb begin
    npc = seq_pc;
    case (sel_eff)
      2'd1:    npc = br_cond ? br_target : seq_pc;
      2'd2:    npc = {d_pc_q[31:28], D_imm, 2'b00};
      2'd3:    npc = D_rs_val;
      default: npc = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= PC_RESET;
      d_instr_q <= '0;
      d_pc_q    <= '0;
      d_valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q      <= npc;
      d_instr_q <= fetch_word;
      d_pc_q    <= pc_q;
      d_valid_q <= 1'b1;
    end
  end

endmodule
